hexport_write_arbiter: RTL and testbench

- Shares the 32-bit hex-display PIO between two requesters, e.g. the CPU-side bridge and the accelerator status path.
- Accepts words from either requester through a valid/ready handshake and grants them round-robin.
- Issues each granted word as a single Avalon-MM write to the PIO data register (address 0).
- Enforces a programmable minimum hold time per displayed word, so the display stays readable.

---
 rtl/hexport_write_arbiter.sv | 121 ++++++++++++
 tb/tb_hexport_write_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hexport_write_arbiter.sv
// ============================================================================
// Module      : hexport_write_arbiter
// Description : Round-robin arbiter sharing the 32-bit hex-display PIO between
//               two valid/ready requesters, with a minimum per-word hold time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hexport_write_arbiter #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    output logic        busy,
    output logic        last_grant
);

    localparam logic        c_NO_HOLD   = (HOLD_CYCLES == 0);
    localparam logic [15:0] c_HOLD_LOAD = (HOLD_CYCLES == 0) ? 16'd0 : 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] data_q;
    logic        last_grant_q;
    logic [15:0] hold_cnt_q;
    logic        cs_q;
    logic        write_n_q;
    logic        busy_q;

    logic        w_grant;
    logic        w_idle_ok;
    logic        w_accept;
    logic [31:0] w_grant_data;

    // On contention the requester that did not win last time is served,
    // which makes grants strictly alternate under continuous demand.
    always_comb begin
        w_grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        w_idle_ok    = (state_q == ST_IDLE) && !reset;
        req0_ready   = w_idle_ok && !w_grant && req0_valid;
        req1_ready   = w_idle_ok &&  w_grant && req1_valid;
        w_accept     = req0_ready || req1_ready;
        w_grant_data = w_grant ? req1_data : req0_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            data_q       <= 32'd0;
            last_grant_q <= 1'b1;
            hold_cnt_q   <= 16'd0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        data_q       <= w_grant_data;
                        last_grant_q <= w_grant;
                        state_q      <= ST_WRITE;
                        cs_q         <= 1'b1;
                        write_n_q    <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // The PIO has no waitrequest: the strobe lasts one cycle.
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                    if (c_NO_HOLD) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= c_HOLD_LOAD;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address    = 2'b00;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = data_q;
    assign busy           = busy_q;
    assign last_grant     = last_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_hexport_write_arbiter.sv
// ============================================================================
// Module      : tb_hexport_write_arbiter
// Description : Directed self-checking bench for hexport_write_arbiter
//               (one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hexport_write_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: HOLD_CYCLES=4
    logic        a_v0 = 0, a_v1 = 0, a_r0, a_r1, a_cs, a_wn, a_busy, a_lg;
    logic [31:0] a_d0 = 0, a_d1 = 0, a_wd;
    logic [1:0]  a_addr;
    // Instance B: HOLD_CYCLES=0
    logic        b_v0 = 0, b_v1 = 0, b_r0, b_r1, b_cs, b_wn, b_busy, b_lg;
    logic [31:0] b_d0 = 0, b_d1 = 0, b_wd;
    logic [1:0]  b_addr;

    hexport_write_arbiter #(.HOLD_CYCLES(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
        .avm_address(a_addr), .avm_chipselect(a_cs), .avm_write_n(a_wn),
        .avm_writedata(a_wd), .busy(a_busy), .last_grant(a_lg)
    );

    hexport_write_arbiter #(.HOLD_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .avm_address(b_addr), .avm_chipselect(b_cs), .avm_write_n(b_wn),
        .avm_writedata(b_wd), .busy(b_busy), .last_grant(b_lg)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Scoreboard of observed PIO writes and accepted handshakes
    logic [31:0] wa_data[$], wb_data[$];
    int          wa_cyc[$],  wb_cyc[$];
    int both_a = 0, both_b = 0, r0_seen_a = 0, acc_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_cs && !a_wn) begin wa_data.push_back(a_wd); wa_cyc.push_back(cyc); end
        if (b_cs && !b_wn) begin wb_data.push_back(b_wd); wb_cyc.push_back(cyc); end
        if (a_r0 && a_r1) both_a++;
        if (b_r0 && b_r1) both_b++;
        if (a_r0) r0_seen_a++;
        if ((a_v0 && a_r0) || (a_v1 && a_r1)) acc_a++;
    end

    task automatic clear_sb();
        wa_data.delete(); wb_data.delete(); wa_cyc.delete(); wb_cyc.delete();
        both_a = 0; both_b = 0; r0_seen_a = 0; acc_a = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_v0 = 0; a_v1 = 0; b_v0 = 0; b_v1 = 0;
        repeat (2) @(posedge clk);
        #1;
        clear_sb();
        reset = 1'b0;
    endtask

    task automatic set_req(input int dut, input int rq, input logic v, input logic [31:0] d);
        case ({dut[0], rq[0]})
            2'b00: begin a_v0 = v; a_d0 = d; end
            2'b01: begin a_v1 = v; a_d1 = d; end
            2'b10: begin b_v0 = v; b_d0 = d; end
            default: begin b_v1 = v; b_d1 = d; end
        endcase
    endtask

    function automatic logic rdy(input int dut, input int rq);
        case ({dut[0], rq[0]})
            2'b00:   return a_r0;
            2'b01:   return a_r1;
            2'b10:   return b_r0;
            default: return b_r1;
        endcase
    endfunction

    // Presents a word and returns just after the edge at which it is accepted.
    task automatic send(input int dut, input int rq, input logic [31:0] d);
        bit got = 0;
        set_req(dut, rq, 1'b1, d);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rdy(dut, rq)) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout dut=%0d req=%0d data=%h: ready=0 required=1", dut, rq, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_v1 = 1; a_d1 = 32'hDEAD; b_v0 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_busy, a_cs, a_wn, a_lg, a_r0, a_r1} !== 6'b001100) begin
            errors++;
            $display("FAIL reset_ctrl_a: busy,cs,wn,lg,r0,r1=%b required 001100",
                     {a_busy, a_cs, a_wn, a_lg, a_r0, a_r1});
        end
        checks++;
        if (a_wd !== 32'd0) begin
            errors++; $display("FAIL reset_wdata_a: got %h required 00000000", a_wd);
        end
        checks++;
        if ({b_busy, b_cs, b_wn, b_lg, b_r0, b_r1} !== 6'b001100) begin
            errors++;
            $display("FAIL reset_ctrl_b: busy,cs,wn,lg,r0,r1=%b required 001100",
                     {b_busy, b_cs, b_wn, b_lg, b_r0, b_r1});
        end
        a_v1 = 0; b_v0 = 0;
    endtask

    task automatic test_single();
        do_reset();
        a_v0 = 1; a_d0 = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if ({a_r0, a_r1} !== 2'b10) begin
            errors++; $display("FAIL single_ready: r0,r1=%b required 10", {a_r0, a_r1});
        end
        @(posedge clk); #1;
        a_v0 = 0;
        @(negedge clk);
        checks++;
        if ({a_cs, a_wn, a_addr, a_busy, a_lg} !== 6'b100010 || a_wd !== 32'h0000_1234) begin
            errors++;
            $display("FAIL single_write: cs,wn,addr,busy,lg=%b wdata=%h required 100010 / 00001234",
                     {a_cs, a_wn, a_addr, a_busy, a_lg}, a_wd);
        end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if ({a_busy, a_cs, a_wn} !== {(k != 6), 2'b01}) begin
                errors++;
                $display("FAIL single_hold T+%0d: busy,cs,wn=%b required %b",
                         k, {a_busy, a_cs, a_wn}, {(k != 6), 2'b01});
            end
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp [4];
        exp[0] = 32'hA0; exp[1] = 32'hB1; exp[2] = 32'hA0; exp[3] = 32'hB1;
        reset = 1'b1;
        a_v0 = 1; a_d0 = 32'hA0; a_v1 = 1; a_d1 = 32'hB1;
        repeat (2) @(posedge clk);
        #1;
        clear_sb();
        reset = 1'b0;
        for (int i = 0; i < 100 && wa_data.size() < 4; i++) @(negedge clk);
        checks++;
        if (wa_data.size() < 4) begin
            errors++; $display("FAIL contention_count: got %0d writes required 4", wa_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa_data[i] !== exp[i]) begin
                    errors++; $display("FAIL contention_data[%0d]: got %h required %h", i, wa_data[i], exp[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa_cyc[i+1] - wa_cyc[i] != 6) begin
                    errors++;
                    $display("FAIL contention_spacing[%0d]: got %0d required 6", i, wa_cyc[i+1] - wa_cyc[i]);
                end
            end
        end
        checks++;
        if (both_a != 0) begin
            errors++; $display("FAIL contention_both_ready: got %0d cycles required 0", both_a);
        end
        a_v0 = 0; a_v1 = 0;
    endtask

    task automatic test_req1_only();
        do_reset();
        send(0, 1, 32'h1);
        send(0, 1, 32'h2);
        send(0, 1, 32'h3);
        a_v1 = 0;
        for (int i = 0; i < 40 && wa_data.size() < 3; i++) @(negedge clk);
        checks++;
        if (wa_data.size() != 3) begin
            errors++; $display("FAIL req1_count: got %0d writes required 3", wa_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa_data[i] !== 32'(i + 1)) begin
                    errors++; $display("FAIL req1_data[%0d]: got %h required %h", i, wa_data[i], 32'(i + 1));
                end
            end
            checks++;
            if (wa_cyc[1] - wa_cyc[0] != 6 || wa_cyc[2] - wa_cyc[1] != 6) begin
                errors++;
                $display("FAIL req1_spacing: got %0d,%0d required 6,6",
                         wa_cyc[1] - wa_cyc[0], wa_cyc[2] - wa_cyc[1]);
            end
        end
        checks++;
        if (r0_seen_a != 0 || a_lg !== 1'b1) begin
            errors++;
            $display("FAIL req1_grant: req0_ready cycles=%0d last_grant=%b required 0 / 1", r0_seen_a, a_lg);
        end
    endtask

    task automatic test_hold0_stream();
        do_reset();
        for (int i = 0; i < 8; i++) send(1, 0, 32'h10 + 32'(i));
        b_v0 = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (wb_data.size() != 8) begin
            errors++; $display("FAIL hold0_count: got %0d writes required 8", wb_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wb_data[i] !== 32'h10 + 32'(i)) begin
                    errors++; $display("FAIL hold0_data[%0d]: got %h required %h", i, wb_data[i], 32'h10 + 32'(i));
                end
                if (i > 0) begin
                    checks++;
                    if (wb_cyc[i] - wb_cyc[i-1] != 2) begin
                        errors++;
                        $display("FAIL hold0_spacing[%0d]: got %0d required 2", i, wb_cyc[i] - wb_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        bit got;
        do_reset();
        send(0, 0, 32'hFFFF_FFFF);
        a_v0 = 0;
        a_v1 = 1; a_d1 = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_cs !== 1'b0) begin
            errors++; $display("FAIL midreset_pre: busy,cs=%b required 10", {a_busy, a_cs});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_busy, a_cs, a_wn, a_lg, a_r0, a_r1} !== 6'b001100 || a_wd !== 32'd0) begin
            errors++;
            $display("FAIL midreset_vals: busy,cs,wn,lg,r0,r1=%b wdata=%h required 001100 / 0",
                     {a_busy, a_cs, a_wn, a_lg, a_r0, a_r1}, a_wd);
        end
        a_v0 = 1; a_d0 = 32'h66;
        @(posedge clk); #1;
        clear_sb();
        reset = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_r0 || a_r1) got = 1;
        end
        checks++;
        if ({a_r0, a_r1} !== 2'b10) begin
            errors++; $display("FAIL midreset_priority: r0,r1=%b required 10", {a_r0, a_r1});
        end
        @(posedge clk); #1;
        a_v0 = 0;
        send(0, 1, 32'h55);
        a_v1 = 0;
        for (int i = 0; i < 20 && wa_data.size() < 2; i++) @(negedge clk);
        checks++;
        if (wa_data.size() != 2 || wa_data[0] !== 32'h66 || wa_data[1] !== 32'h55) begin
            errors++;
            $display("FAIL midreset_order: got %0d writes first=%h required 2 writes 66,55",
                     wa_data.size(), (wa_data.size() > 0) ? wa_data[0] : 32'hX);
        end
    endtask

    task automatic test_drop_while_busy();
        do_reset();
        send(0, 1, 32'h77);
        a_v1 = 0;
        @(posedge clk); #1;
        a_v0 = 1; a_d0 = 32'h88;
        @(negedge clk);
        checks++;
        if (a_r0 !== 1'b0) begin
            errors++; $display("FAIL drop_ready: req0_ready=%b required 0", a_r0);
        end
        @(posedge clk); #1;
        a_v0 = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (wa_data.size() != 1 || wa_data[0] !== 32'h77) begin
            errors++;
            $display("FAIL drop_writes: got %0d writes first=%h required 1 write 77",
                     wa_data.size(), (wa_data.size() > 0) ? wa_data[0] : 32'hX);
        end
        checks++;
        if (acc_a != wa_data.size()) begin
            errors++; $display("FAIL drop_scoreboard: accepted=%0d writes=%0d required equal", acc_a, wa_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_req1_only();
        test_hold0_stream();
        test_reset_mid_hold();
        test_drop_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
